// File: rtl/mux_21.sv
// 2:1 bit-steering selector for the ALU datapath: combinational result plus a
// one-cycle registered copy that clears asynchronously on reset.
module mux_21 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_comb
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $error("mux_21: WIDTH must be in 1..64");
  end

  logic [WIDTH-1:0] y_p0;

  always_comb begin
    y_comb = s ? in1 : in0;
  end

  // stage p0: registered copy, reloaded every edge, no enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p0 <= '0;
    end else begin
      y_p0 <= y_comb;
    end
  end

  assign y = y_p0;

endmodule

// File: tb/tb_mux_21.sv
// Self-checking bench for mux_21: a WIDTH=1 and a WIDTH=4 instance share clock,
// reset and select; expectations come from an array-indexed selection model.
module tb_mux_21;

  logic       clk;
  logic       rst_n;
  logic       s;
  logic [0:0] in0_1, in1_1, y_1, y_comb_1;
  logic [3:0] in0_4, in1_4, y_4, y_comb_4;

  int n_chk  = 0;
  int n_pass = 0;

  mux_21 #(.WIDTH(1)) u_mux_w1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .s      (s),
    .in0    (in0_1),
    .in1    (in1_1),
    .y      (y_1),
    .y_comb (y_comb_1)
  );

  mux_21 #(.WIDTH(4)) u_mux_w4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .s      (s),
    .in0    (in0_4),
    .in1    (in1_4),
    .y      (y_4),
    .y_comb (y_comb_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Selection model: the select line indexes a table of the two candidates.
  function automatic logic [3:0] ref_mux(input logic sel, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] opts [2];
    opts[0] = a;
    opts[1] = b;
    return opts[sel];
  endfunction

  logic [7:0] tt_exp;
  logic [3:0] exp_y1, exp_y4;

  initial begin
    tt_exp = 8'b1010_1100;
    rst_n = 1'b0;
    s     = 1'b0;
    in0_1 = 1'b1;
    in1_1 = 1'b0;
    in0_4 = 4'h3;
    in1_4 = 4'hC;

    // Reset state
    #1;
    check("rst_y1", 64'(y_1), 64'd0);
    check("rst_y4", 64'(y_4), 64'd0);
    check("rst_ycomb4", 64'(y_comb_4), 64'h3);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_y4", 64'(y_4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive truth table, 100 ns per step
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {s, in0_1, in1_1} = 3'(i);
      in0_4 = 4'($urandom);
      in1_4 = 4'($urandom);
      #1;
      check($sformatf("tt_ycomb_%0d", i), 64'(y_comb_1), 64'(tt_exp[i]));
      check($sformatf("tt_ycomb4_%0d", i), 64'(y_comb_4), 64'(ref_mux(s, in0_4, in1_4)));
      @(posedge clk);
      #1;
      check($sformatf("tt_y_%0d", i), 64'(y_1), 64'(tt_exp[i]));
      check($sformatf("tt_y4_%0d", i), 64'(y_4), 64'(ref_mux(s, in0_4, in1_4)));
      repeat (9) @(posedge clk);
    end

    // Asynchronous reset between edges
    @(negedge clk);
    s = 1'b1;
    in1_1 = 1'b1;
    in1_4 = 4'h9;
    @(posedge clk);
    #1;
    check("ar_y_loaded", 64'(y_1), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_y_cleared", 64'(y_1), 64'd0);
    check("ar_y4_cleared", 64'(y_4), 64'd0);
    check("ar_ycomb_kept", 64'(y_comb_1), 64'd1);
    check("ar_ycomb4_kept", 64'(y_comb_4), 64'h9);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ar_y_no_restore", 64'(y_1), 64'd0);
    @(posedge clk);
    #1;
    check("ar_y_reload", 64'(y_1), 64'd1);
    check("ar_y4_reload", 64'(y_4), 64'h9);

    // Select toggling with equal data
    @(negedge clk);
    in0_1 = 1'b1;
    in1_1 = 1'b1;
    in0_4 = 4'h6;
    in1_4 = 4'h6;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s = ~s;
      #1;
      check($sformatf("eq_ycomb_%0d", i), 64'(y_comb_1), 64'd1);
      check($sformatf("eq_ycomb4_%0d", i), 64'(y_comb_4), 64'h6);
      @(posedge clk);
      #1;
      check($sformatf("eq_y_%0d", i), 64'(y_1), 64'd1);
      check($sformatf("eq_y4_%0d", i), 64'(y_4), 64'h6);
    end

    // Wide datapath
    @(negedge clk);
    in0_4 = 4'hA;
    in1_4 = 4'h5;
    s = 1'b0;
    #1;
    check("wide_ycomb_s0", 64'(y_comb_4), 64'hA);
    check("wide_y_lag", 64'(y_4), 64'h6);
    @(posedge clk);
    #1;
    check("wide_y_s0", 64'(y_4), 64'hA);
    @(negedge clk);
    s = 1'b1;
    #1;
    check("wide_ycomb_s1", 64'(y_comb_4), 64'h5);
    check("wide_y_hold", 64'(y_4), 64'hA);
    @(posedge clk);
    #1;
    check("wide_y_s1", 64'(y_4), 64'h5);

    // Mid-cycle select glitch
    @(negedge clk);
    s = 1'b0;
    in0_1 = 1'b0;
    in1_1 = 1'b1;
    @(posedge clk);
    #1;
    check("gl_y_before", 64'(y_1), 64'd0);
    #2;
    s = 1'b1;
    #1;
    check("gl_ycomb_pulse", 64'(y_comb_1), 64'd1);
    #1;
    s = 1'b0;
    #1;
    check("gl_ycomb_back", 64'(y_comb_1), 64'd0);
    @(posedge clk);
    #1;
    check("gl_y_after", 64'(y_1), 64'd0);

    // Random activity with a 3-cycle reset in the middle
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      s     = 1'($urandom);
      in0_1 = 1'($urandom);
      in1_1 = 1'($urandom);
      in0_4 = 4'($urandom);
      in1_4 = 4'($urandom);
      if (c == 15) rst_n = 1'b0;
      if (c == 18) rst_n = 1'b1;
      #1;
      check($sformatf("rnd_ycomb1_%0d", c), 64'(y_comb_1), 64'(ref_mux(s, 4'(in0_1), 4'(in1_1))));
      check($sformatf("rnd_ycomb4_%0d", c), 64'(y_comb_4), 64'(ref_mux(s, in0_4, in1_4)));
      if (!rst_n) begin
        check($sformatf("rnd_rst_y4_%0d", c), 64'(y_4), 64'd0);
      end
      exp_y1 = rst_n ? ref_mux(s, 4'(in0_1), 4'(in1_1)) : 4'd0;
      exp_y4 = rst_n ? ref_mux(s, in0_4, in1_4) : 4'd0;
      @(posedge clk);
      #1;
      check($sformatf("rnd_y1_%0d", c), 64'(y_1), 64'(exp_y1));
      check($sformatf("rnd_y4_%0d", c), 64'(y_4), 64'(exp_y4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
